logit_argmax_seq: RTL and testbench
===================================

# logit_argmax_seq

Sequential argmax engine that shares one signed comparator across all output-layer logits. Layer 2 streams its logits one per handshake; the block tracks the running maximum and its index, then presents the winning class to the output stage with a valid/ready handshake. It replaces the 9-comparator combinational tree where area is tighter than latency.

## Interface
- N_CLASSES, 10: logits per frame (2..16).
- LOGIT_W, 6: signed logit width.
- IDX_W, 4: index width; must satisfy 2^IDX_W ≥ N_CLASSES.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_clr  in  1  synchronous abort: discard the partial frame or held result.
- in_valid  in  1  logit available.
- in_ready  out  1  block accepts a logit this cycle.
- in_logit  in  LOGIT_W  signed two's-complement logit; class index is implied by arrival order.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_index  out  IDX_W  class index of the maximum.
- out_max  out  LOGIT_W  maximum logit value (signed).
- out_margin  out  LOGIT_W+1  unsigned max minus second-max; present only with ARGMAX_MARGIN_EN.

## Operation
- Two-state FSM: COLLECT (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1). in_ready and out_valid decode directly from the state register.
- Accept occurs when in_valid && in_ready. Class counter cnt (IDX_W bits) starts at 0 and increments on each accept.
- Accept with cnt==0: max←in_logit, idx←0 unconditionally.
- Accept with cnt>0: if in_logit > max (signed, strict), then max←in_logit and idx←cnt; otherwise hold. On ties the first occurrence wins (lowest index).
- Accept with cnt==N_CLASSES-1: after the update, go to DONE and clear cnt to 0. Logits past the frame length are never accepted.
- DONE: out_index, out_max, and out_margin stay stable while out_valid=1. When out_valid && out_ready, go to COLLECT. No input is accepted in the same cycle as the result is taken.
- frame_clr has the highest priority. It forces COLLECT, clears cnt, and drops out_valid next cycle. Any accept or out handshake in the same cycle is discarded. out_* data registers keep their values.
- in_logit values are signed across the full range. -2^(LOGIT_W-1) is a legal logit.

## Timing
- Reset values: state=COLLECT, in_ready=1, out_valid=0, cnt=0, out_index=0, out_max=0, out_margin=0.
- Reset may be asserted mid-frame or in DONE. Reset wins immediately (asynchronous) and the partial frame is lost.
- Latency: out_valid rises on the first clock edge after the accept of the last logit.
- Throughput: N_CLASSES+1 cycles per frame with in_valid=out_ready=1 continuously (10 accepts + 1 DONE cycle).
- Combinational paths: none from inputs to outputs. All outputs are registered or decoded from registered state.
- Backpressure: the logit source must hold in_logit stable while in_valid=1 && in_ready=0. In DONE, the block stalls the source until the result is consumed.

## Configuration
- ARGMAX_MARGIN_EN defined:
  - A second-max register sec is added.
  - cnt==0 accept: sec←-2^(LOGIT_W-1).
  - On a new max: sec←old max.
  - Otherwise: sec←larger of sec and in_logit. A tie with max therefore gives margin 0.
  - out_margin = max − sec, zero-extended to LOGIT_W+1 bits, registered with out_max.
- ARGMAX_MARGIN_EN undefined: no sec register, no out_margin port. All other behaviour is identical.

## Test plan
- Frame 3,-5,7,1,0,7,-32,2,6,-1 with out_ready=1 → out_index=2, out_max=7, margin=0. out_valid high exactly one cycle, at cycle 11 after the first accept.
- All ten logits = -32 → out_index=0, out_max=-32, margin=0. Separately, logit 31 at class 9 with all others -32 → out_index=9, margin=63.
- Random in_valid gaps plus out_ready held low 5 cycles in DONE → in_ready=0 and outputs stable throughout. After out_ready, the next frame's first logit is accepted one cycle later.
- frame_clr asserted after 4 accepts, then a full new frame with the max at class 5 → out_index=5. The aborted logits have no influence.
- rst_n pulsed low in DONE, and again mid-frame → all outputs at reset values asynchronously. The following frame produces a correct result.
- 100 random frames vs. a reference model (first-max tie rule), back-to-back → every result matches. Throughput is 11 cycles per frame.

Source files
------------

// File: rtl/logit_argmax_seq.sv
// Sequential argmax over a streamed frame of signed logits, one shared comparator.
// Define ARGMAX_MARGIN_EN to add the second-max tracker and the out_margin port.
module logit_argmax_seq #(
    parameter int N_CLASSES = 10,
    parameter int LOGIT_W   = 6,
    parameter int IDX_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LOGIT_W-1:0] in_logit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_index,
    output logic [LOGIT_W-1:0] out_max
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [LOGIT_W:0]   out_margin
`endif
);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_DONE    = 1'b1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [LOGIT_W-1:0] r_max;

    logic               w_accept;
    logic               w_first;
    logic               w_last;
    logic               w_gt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [LOGIT_W-1:0] w_max_nxt;

    assign in_ready  = (r_state == S_COLLECT);
    assign out_valid = (r_state == S_DONE);

    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == LAST);
    // Strict compare: equal values never displace the earlier class
    assign w_gt      = $signed(in_logit) > $signed(r_max);
    assign w_max_nxt = (w_first || w_gt) ? in_logit : r_max;
    assign w_idx_nxt = w_first ? '0 : (w_gt ? r_cnt : r_idx);

`ifdef ARGMAX_MARGIN_EN
    localparam logic [LOGIT_W-1:0] MIN_LOGIT = {1'b1, {(LOGIT_W-1){1'b0}}};

    logic [LOGIT_W-1:0] r_sec;
    logic [LOGIT_W-1:0] w_sec_nxt;
    logic [LOGIT_W:0]   w_margin;

    always_comb begin
        w_sec_nxt = r_sec;
        if (w_first)
            w_sec_nxt = MIN_LOGIT;
        else if (w_gt)
            w_sec_nxt = r_max;
        else if ($signed(in_logit) > $signed(r_sec))
            w_sec_nxt = in_logit;
    end

    // max >= sec always, so the sign-extended difference fits unsigned
    assign w_margin = {w_max_nxt[LOGIT_W-1], w_max_nxt}
                    - {w_sec_nxt[LOGIT_W-1], w_sec_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec      <= '0;
            out_margin <= '0;
        end else if (!frame_clr && w_accept) begin
            r_sec <= w_sec_nxt;
            if (w_last)
                out_margin <= w_margin;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_COLLECT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_max     <= '0;
            out_index <= '0;
            out_max   <= '0;
        end else if (frame_clr) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_max <= w_max_nxt;
                        r_idx <= w_idx_nxt;
                        if (w_last) begin
                            r_state   <= S_DONE;
                            r_cnt     <= '0;
                            out_index <= w_idx_nxt;
                            out_max   <= w_max_nxt;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_logit_argmax_seq.sv
// Randomized and directed bench for logit_argmax_seq with a frame-level reference model.
// Honors ARGMAX_MARGIN_EN in the same way as the design.
`timescale 1ns/1ps
module tb_logit_argmax_seq;

    localparam int NC = 10;
    localparam int LW = 6;
    localparam int IW = 4;

    logic          clk;
    logic          rst_n;
    logic          frame_clr;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_logit;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_index;
    logic [LW-1:0] out_max;
`ifdef ARGMAX_MARGIN_EN
    logic [LW:0]   out_margin;
`endif

    logit_argmax_seq #(.N_CLASSES(NC), .LOGIT_W(LW), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_clr (frame_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_logit  (in_logit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_max   (out_max)
`ifdef ARGMAX_MARGIN_EN
        ,
        .out_margin(out_margin)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit started = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame contents plus the result the spec's rules imply
    int q[$];
    bit m_done = 0;
    int m_idx = 0;
    int m_max = 0;
    int m_sec = 0;

    task automatic compute_result();
        int bi;
        int bv;
        int sv;
        bi = 0;
        bv = q[0];
        for (int i = 1; i < NC; i++)
            if (q[i] > bv) begin
                bi = i;
                bv = q[i];
            end
        sv = -(1 << (LW - 1));
        for (int j = 0; j < NC; j++)
            if (j != bi && q[j] > sv)
                sv = q[j];
        m_idx = bi;
        m_max = bv;
        m_sec = sv;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_done = 0;
            q.delete();
            m_idx = 0;
            m_max = 0;
            m_sec = 0;
        end else if (frame_clr) begin
            m_done = 0;
            q.delete();
        end else if (!m_done) begin
            if (in_valid) begin
                q.push_back(int'($signed(in_logit)));
                if (q.size() == NC) begin
                    compute_result();
                    m_done = 1;
                    q.delete();
                end
            end
        end else if (out_ready) begin
            m_done = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started && rst_n) begin
            chk("in_ready", int'(in_ready), int'(!m_done));
            chk("out_valid", int'(out_valid), int'(m_done));
            chk("out_index", int'(out_index), m_idx);
            chk("out_max", int'($signed(out_max)), m_max);
`ifdef ARGMAX_MARGIN_EN
            chk("out_margin", int'(out_margin), m_max - m_sec);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int v, output int acc);
        int t;
        t = 0;
        in_valid = 1;
        in_logit = LW'(v);
        @(negedge clk);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
        end
        @(posedge clk);
        #2;
        in_valid = 0;
        acc = cyc;
    endtask

    task automatic send(input int a[NC], input bit gaps, output int first);
        int acc;
        first = 0;
        for (int i = 0; i < NC; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) step();
            push(a[i], acc);
            if (i == 0)
                first = acc;
        end
    endtask

    task automatic expect_res(input string nm, input int idx, input int mx, input int mg);
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_index"}, int'(out_index), idx);
        chk({nm, "_max"}, int'($signed(out_max)), mx);
`ifdef ARGMAX_MARGIN_EN
        chk({nm, "_margin"}, int'(out_margin), mg);
`else
        if (mg < 0) $display("note: negative margin %0d", mg);
`endif
    endtask

    task automatic expect_reset(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_index"}, int'(out_index), 0);
        chk({nm, "_max"}, int'(out_max), 0);
`ifdef ARGMAX_MARGIN_EN
        chk({nm, "_margin"}, int'(out_margin), 0);
`endif
    endtask

    task automatic wait_valid(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1", nm);
        end
    endtask

    int f1[NC]   = '{3, -5, 7, 1, 0, 7, -32, 2, 6, -1};
    int fmin[NC] = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32};
    int f31[NC]  = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, 31};
    int fgap[NC] = '{-1, 4, 12, -7, 12, 0, 5, -20, 11, 3};
    int fclr[NC] = '{1, 2, 3, 4, -8, 20, 19, 0, -3, 5};
    int fneg[NC] = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -11};

    initial begin
        int first;
        int prev;
        int acc;
        int rnd[NC];
        rst_n = 1;
        frame_clr = 0;
        in_valid = 0;
        in_logit = '0;
        out_ready = 1;
        #1 rst_n = 0;
        #10;
        expect_reset("reset");
        #2 rst_n = 1;
        started = 1;
        step();

        send(f1, 0, first);
        @(negedge clk);
        chk("f1_latency", cyc - first, 9);
        expect_res("f1", 2, 7, 0);
        @(negedge clk);
        chk("f1_valid_one_cycle", int'(out_valid), 0);
        step();

        send(fmin, 0, first);
        @(negedge clk);
        expect_res("fmin", 0, -32, 0);
        step();
        send(f31, 0, first);
        @(negedge clk);
        expect_res("f31", 9, 31, 63);
        step();

        out_ready = 0;
        send(fgap, 1, first);
        wait_valid("gap");
        expect_res("gap", 2, 12, 0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", int'(in_ready), 0);
            expect_res("stall", 2, 12, 0);
        end
        step();
        prev = cyc;
        out_ready = 1;
        push(9, acc);
        chk("resume_accept_cycle", acc - prev, 2);
        for (int i = 0; i < 3; i++) push(31, acc);
        frame_clr = 1;
        step();
        frame_clr = 0;
        send(fclr, 0, first);
        @(negedge clk);
        expect_res("fclr", 5, 20, 1);
        step();

        out_ready = 0;
        send(f1, 1, first);
        wait_valid("rst_done");
        #1 rst_n = 0;
        #1 expect_reset("rst_in_done");
        #1 rst_n = 1;
        out_ready = 1;
        step();
        for (int i = 0; i < 4; i++) push(30, acc);
        #1 rst_n = 0;
        #1 expect_reset("rst_mid_frame");
        #1 rst_n = 1;
        step();
        send(fneg, 0, first);
        @(negedge clk);
        expect_res("fneg", 8, -2, 1);
        step();

        prev = -1;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < NC; i++)
                rnd[i] = (f % 2 == 0) ? $urandom_range(0, 63) - 32
                                      : $urandom_range(0, 3) - 2;
            send(rnd, 0, first);
            if (prev >= 0)
                chk("throughput", first - prev, NC + 1);
            prev = first;
        end
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
